// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time frame format and break detection.
// Define UART_RX_PARITY_EN to build in the parity bit state and check.
module uart_rx_cfg #(
  parameter int MAX_BITS = 8,
  parameter int DIV_W    = 16
) (
  input  logic                i_Clock,
  input  logic                i_Rst_n,
  input  logic                i_Rx_Serial,
  input  logic [DIV_W-1:0]    i_Clks_Per_Bit,
  input  logic [3:0]          i_Data_Bits,
  input  logic [1:0]          i_Parity_Mode,
  input  logic                i_Two_Stop,
  output logic                o_Rx_DV,
  output logic [MAX_BITS-1:0] o_Rx_Byte,
  output logic                o_Parity_Err,
  output logic                o_Frame_Err,
  output logic                o_Break,
  output logic                o_Busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BRK    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          nb_q, nb_d;
  logic [3:0]          bit_q, bit_d;
  logic                two_q, two_d;
  logic                stop2_q, stop2_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic                zero_q, zero_d;
  logic                fa_q, fa_d;
  logic                dv_q, dv_d;
  logic [MAX_BITS-1:0] byte_q, byte_d;
  logic                ferr_q, ferr_d;
  logic                brk_q, brk_d;
`ifdef UART_RX_PARITY_EN
  logic                pen_q, pen_d;
  logic                odd_q, odd_d;
  logic                px_q, px_d;
  logic                pa_q, pa_d;
  logic                perr_q, perr_d;
`else
  logic                unused_pm;
  assign unused_pm = ^i_Parity_Mode;
`endif

  logic                rx_s;
  logic [DIV_W-1:0]    div_eff, last_w, half_w;
  logic [3:0]          nb_eff;
  logic                samp;

  assign rx_s    = rx_sync_q;
  assign div_eff = (i_Clks_Per_Bit < DIV_W'(4)) ? DIV_W'(4) : i_Clks_Per_Bit;
  assign nb_eff  = (i_Data_Bits < 4'd5 || i_Data_Bits > 4'(MAX_BITS))
                 ? 4'(MAX_BITS) : i_Data_Bits;
  assign last_w  = div_q - DIV_W'(1);
  assign half_w  = last_w >> 1;
  assign samp    = (cnt_q == last_w);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    nb_d    = nb_q;
    bit_d   = bit_q;
    two_d   = two_q;
    stop2_d = stop2_q;
    data_d  = data_q;
    zero_d  = zero_q;
    fa_d    = fa_q;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    ferr_d  = 1'b0;
    brk_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    pen_d   = pen_q;
    odd_d   = odd_q;
    px_d    = px_q;
    pa_d    = pa_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          div_d   = div_eff;
          nb_d    = nb_eff;
          two_d   = i_Two_Stop;
          cnt_d   = '0;
          bit_d   = '0;
          stop2_d = 1'b0;
          data_d  = '0;
          zero_d  = 1'b1;
          fa_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
          pen_d   = (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
          odd_d   = (i_Parity_Mode == 2'b10);
          px_d    = 1'b0;
          pa_d    = 1'b0;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == half_w) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (samp) begin
          cnt_d = '0;
          for (int k = 0; k < MAX_BITS; k++)
            if (bit_q == 4'(k)) data_d[k] = rx_s;
          zero_d = zero_q & ~rx_s;
`ifdef UART_RX_PARITY_EN
          px_d = px_q ^ rx_s;
`endif
          if (bit_q == nb_q - 4'd1) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = pen_q ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (samp) begin
          cnt_d   = '0;
          pa_d    = px_q ^ rx_s ^ odd_q;
          zero_d  = zero_q & ~rx_s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (samp) begin
          cnt_d = '0;
          if (!two_q || stop2_q) begin
            dv_d    = 1'b1;
            byte_d  = data_q;
            ferr_d  = fa_q | ~rx_s;
            brk_d   = zero_q & ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = pa_q;
`endif
            stop2_d = 1'b0;
            state_d = rx_s ? S_IDLE : S_BRK;
          end else begin
            stop2_d = 1'b1;
            zero_d  = zero_q & ~rx_s;
            fa_d    = fa_q | ~rx_s;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      // line held low after a frame: wait quietly for idle
      S_BRK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= S_IDLE;
      div_q     <= DIV_W'(4);
      cnt_q     <= '0;
      nb_q      <= 4'(MAX_BITS);
      bit_q     <= '0;
      two_q     <= 1'b0;
      stop2_q   <= 1'b0;
      data_q    <= '0;
      zero_q    <= 1'b0;
      fa_q      <= 1'b0;
      dv_q      <= 1'b0;
      byte_q    <= '0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pen_q     <= 1'b0;
      odd_q     <= 1'b0;
      px_q      <= 1'b0;
      pa_q      <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      nb_q      <= nb_d;
      bit_q     <= bit_d;
      two_q     <= two_d;
      stop2_q   <= stop2_d;
      data_q    <= data_d;
      zero_q    <= zero_d;
      fa_q      <= fa_d;
      dv_q      <= dv_d;
      byte_q    <= byte_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
`ifdef UART_RX_PARITY_EN
      pen_q     <= pen_d;
      odd_q     <= odd_d;
      px_q      <= px_d;
      pa_q      <= pa_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_Rx_DV     = dv_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Frame_Err = ferr_q;
  assign o_Break     = brk_q;
  assign o_Busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_q;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frame formats, errors, break,
// glitch rejection and mid-frame reset.
module tb_uart_rx_cfg;
  localparam int MB = 8;
  localparam int DW = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DW-1:0] cfg_div = 16'd16;
  logic [3:0]    cfg_nb = 4'd8;
  logic [1:0]    cfg_pm = 2'b00;
  logic          cfg_two = 1'b0;
  logic          dv, perr, ferr, brk, busy;
  logic [MB-1:0] rbyte;

  int            n_total = 0;
  int            n_bad = 0;
  int            n_dv = 0;
  logic [MB-1:0] cap_byte = '0;
  logic          cap_perr = 1'b0;
  logic          cap_ferr = 1'b0;
  logic          cap_brk = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.MAX_BITS(MB), .DIV_W(DW)) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Rx_Serial    (rx),
    .i_Clks_Per_Bit (cfg_div),
    .i_Data_Bits    (cfg_nb),
    .i_Parity_Mode  (cfg_pm),
    .i_Two_Stop     (cfg_two),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rbyte),
    .o_Parity_Err   (perr),
    .o_Frame_Err    (ferr),
    .o_Break        (brk),
    .o_Busy         (busy)
  );

  always @(negedge clk) begin
    if (dv) begin
      n_dv     = n_dv + 1;
      cap_byte = rbyte;
      cap_perr = perr;
      cap_ferr = ferr;
      cap_brk  = brk;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tx(input logic b, input int div);
    rx = b;
    repeat (div) @(negedge clk);
  endtask

  task automatic send(input logic [8:0] d, input int nb, input int div,
                      input bit use_p, input logic pb,
                      input logic s1, input bit two, input logic s2);
    tx(1'b0, div);
    for (int k = 0; k < nb; k++) tx(d[k], div);
    if (use_p) tx(pb, div);
    tx(s1, div);
    if (two) tx(s2, div);
    rx = 1'b1;
  endtask

  task automatic frame_chk(input string t, input int n0,
                           input int eb, input bit ep,
                           input bit ef, input bit ek);
    chk({t, ".dv"},   n_dv - n0, 1);
    chk({t, ".byte"}, int'(cap_byte), eb);
    chk({t, ".perr"}, int'(cap_perr), int'(ep));
    chk({t, ".ferr"}, int'(cap_ferr), int'(ef));
    chk({t, ".brk"},  int'(cap_brk), int'(ek));
  endtask

  initial begin
    int n0;
    int idle_at;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.dv",   int'(dv), 0);
    chk("rst.byte", int'(rbyte), 0);
    chk("rst.perr", int'(perr), 0);
    chk("rst.ferr", int'(ferr), 0);
    chk("rst.brk",  int'(brk), 0);
    chk("rst.busy", int'(busy), 0);
    repeat (5) @(negedge clk);

    // 8N1 0xA5
    n0 = n_dv;
    send(9'h0A5, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (48) @(negedge clk);
    frame_chk("a5", n0, 'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5.busy", int'(busy), 0);

    // 7E1, wrong parity bit
    cfg_nb = 4'd7; cfg_pm = 2'b01;
    n0 = n_dv;
    send(9'h055, 7, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (48) @(negedge clk);
    frame_chk("p55", n0, 'h55, PEN, 1'b0, 1'b0);

    // 8O1, correct odd parity 0 (stop error if parity absent)
    cfg_nb = 4'd8; cfg_pm = 2'b10;
    n0 = n_dv;
    send(9'h001, 8, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (48) @(negedge clk);
    frame_chk("o01", n0, 'h01, 1'b0, !PEN, 1'b0);

    // 5N2 div 8, second stop bit low
    cfg_div = 16'd8; cfg_nb = 4'd5; cfg_pm = 2'b00; cfg_two = 1'b1;
    n0 = n_dv;
    send(9'h01F, 5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (32) @(negedge clk);
    frame_chk("s1f", n0, 'h1F, 1'b0, 1'b1, 1'b0);
    chk("s1f.busy", int'(busy), 0);

    // break: line low 20 bit times, then 0x3C with config changed mid-frame
    cfg_div = 16'd16; cfg_nb = 4'd8; cfg_two = 1'b0;
    n0 = n_dv;
    rx = 1'b0;
    repeat (320) @(negedge clk);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    frame_chk("brk", n0, 'h00, 1'b0, 1'b1, 1'b1);
    n0 = n_dv;
    fork
      send(9'h03C, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        repeat (20) @(negedge clk);
        cfg_div = 16'd7; cfg_nb = 4'd5; cfg_two = 1'b1;
      end
    join
    repeat (48) @(negedge clk);
    frame_chk("3c", n0, 'h3C, 1'b0, 1'b0, 1'b0);

    // divisor below 4 and out-of-range bit count
    cfg_div = 16'd2; cfg_nb = 4'd15; cfg_two = 1'b0;
    n0 = n_dv;
    send(9'h05A, 8, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    frame_chk("5a", n0, 'h5A, 1'b0, 1'b0, 1'b0);

    // 3-clock glitch
    cfg_div = 16'd16; cfg_nb = 4'd8;
    n0 = n_dv;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    chk("gl.busy_hi", int'(busy), 1);
    idle_at = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!busy && idle_at < 0) idle_at = i;
    end
    chk("gl.busy_lo", int'(idle_at > 0), 1);
    repeat (40) @(negedge clk);
    chk("gl.dv", n_dv - n0, 0);

    // reset during data bit 4
    n0 = n_dv;
    tx(1'b0, 16);
    for (int k = 0; k < 4; k++) tx(1'b1, 16);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("mr.busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr.busy", int'(busy), 0);
    chk("mr.byte", int'(rbyte), 0);
    chk("mr.dv",   int'(dv), 0);
    chk("mr.ferr", int'(ferr), 0);
    chk("mr.brk",  int'(brk), 0);
    repeat (7) @(negedge clk);
    for (int k = 0; k < 4; k++) tx(1'b1, 16);
    repeat (48) @(negedge clk);
    chk("mr.nodv", n_dv - n0, 0);
    n0 = n_dv;
    send(9'h081, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (48) @(negedge clk);
    frame_chk("81", n0, 'h81, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
